// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and size helper for the load/store unit.
package lsu_pkg;

  localparam int LSU_DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RMW_READ,
    ST_WRITE
  } lsu_state_t;

  // Bytes touched by an access; the reserved encoding spans nothing.
  function automatic logic [2:0] size_span(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_span = 3'd1;
      SZ_HALF: size_span = 3'd2;
      SZ_WORD: size_span = 3'd4;
      default: size_span = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_lane_fmt.sv
// Combinational lane formatter: load extract/extend and sub-word store merge.
module lsu_lane_fmt
  import lsu_pkg::*;
(
  input  logic [1:0]            size_i,
  input  logic                  unsigned_i,
  input  logic [LSU_DATA_W-1:0] rdata_i,
  input  logic [LSU_DATA_W-1:0] wdata_i,
  output logic [LSU_DATA_W-1:0] load_o,
  output logic [LSU_DATA_W-1:0] merge_o
);

  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    load_o  = rdata_i;
    merge_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_o  = {{24{~unsigned_i & rdata_i[7]}}, rdata_i[7:0]};
        merge_o = {rdata_i[31:8], wdata_i[7:0]};
      end
      SZ_HALF: begin
        load_o  = {{16{~unsigned_i & rdata_i[15]}}, rdata_i[15:0]};
        merge_o = {rdata_i[31:16], wdata_i[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store controller driving a byte-addressed 32-bit data memory.
// Optional LSU_ALIGN_CHECK_EN rejects misaligned half/word requests.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  output logic              resp_err_o,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic              mem_wrt_en_o,
  output logic [DATA_W-1:0] mem_write_data_o,
  input  logic [DATA_W-1:0] mem_read_data_i
);

  localparam logic [ADDR_W:0] MEM_END = (ADDR_W+1)'(MEM_BYTES);

  lsu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              we_q, we_d;
  logic              uns_q, uns_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

  logic [ADDR_W:0]   req_end;
  logic              misalign;
  logic              req_bad;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] merge_val;

  assign req_end = {1'b0, req_addr_i} + {{(ADDR_W-2){1'b0}}, size_span(req_size_i)};

`ifdef LSU_ALIGN_CHECK_EN
  assign misalign = ((req_size_i == SZ_HALF) && req_addr_i[0]) ||
                    ((req_size_i == SZ_WORD) && (req_addr_i[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_bad = (req_size_i == SZ_RSVD) || (req_end > MEM_END) || misalign;

  lsu_lane_fmt u_lane_fmt (
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .rdata_i    (mem_read_data_i),
    .wdata_i    (wdata_q),
    .load_o     (load_val),
    .merge_o    (merge_val)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    we_d         = we_q;
    uns_d        = uns_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          size_d  = req_size_i;
          we_d    = req_we_i;
          uns_d   = req_unsigned_i;
          wdata_d = req_wdata_i;
          if (req_bad) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (!req_we_i) begin
            state_d = ST_LOAD;
          end else if (req_size_i == SZ_WORD) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_RMW_READ;
          end
        end
      end
      ST_LOAD: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = load_val;
        state_d      = ST_IDLE;
      end
      ST_RMW_READ: begin
        wdata_d = merge_val;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        resp_valid_d = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      size_q       <= '0;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      we_q         <= we_d;
      uns_q        <= uns_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Memory strobes are gated by reset so a reset landing in WRITE cannot commit.
  assign mem_wrt_en_o     = (state_q == ST_WRITE) && rst;
  assign mem_address_o    = ((state_q != ST_IDLE) && rst) ? addr_q : '0;
  assign mem_write_data_o = mem_wrt_en_o ? wdata_q : '0;

  assign req_ready_o  = (state_q == ST_IDLE);
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = resp_rdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: byte-array reference model, directed and random requests.
module tb_lsu_mem_ctrl;

  localparam int MEM_BYTES = 2048;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [10:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [10:0] mem_address;
  logic        mem_wrt_en;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [7:0]  phys_mem [MEM_BYTES];
  logic [7:0]  ref_mem  [MEM_BYTES];
  int          wr_cnt = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_rdata;

  always #5 clk = ~clk;

  lsu_mem_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_we_i         (req_we),
    .req_size_i       (req_size),
    .req_unsigned_i   (req_unsigned),
    .req_addr_i       (req_addr),
    .req_wdata_i      (req_wdata),
    .resp_valid_o     (resp_valid),
    .resp_err_o       (resp_err),
    .resp_rdata_o     (resp_rdata),
    .mem_address_o    (mem_address),
    .mem_wrt_en_o     (mem_wrt_en),
    .mem_write_data_o (mem_write_data),
    .mem_read_data_i  (mem_read_data)
  );

  // Environment memory: combinational little-endian read, full-word write.
  always_comb begin
    mem_read_data = '0;
    for (int k = 0; k < 4; k++) begin
      if (int'(mem_address) + k < MEM_BYTES)
        mem_read_data[8*k +: 8] = phys_mem[int'(mem_address) + k];
    end
  end

  always @(posedge clk) begin
    if (mem_wrt_en) begin
      wr_cnt <= wr_cnt + 1;
      for (int k = 0; k < 4; k++) begin
        if (int'(mem_address) + k < MEM_BYTES)
          phys_mem[int'(mem_address) + k] <= mem_write_data[8*k +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request, predict its outcome from the reference byte array, and check it.
  task automatic do_req(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [10:0] a, input logic [31:0] wd);
    int          span, exp_lat, exp_wr, lat, wr0;
    logic        exp_err;
    logic [31:0] exp_rd;
    span    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    exp_err = (sz == 2'b11) || (int'(a) + span > MEM_BYTES);
`ifdef LSU_ALIGN_CHECK_EN
    if (sz == 2'b01 && a[0]) exp_err = 1'b1;
    if (sz == 2'b10 && a[1:0] != 2'b00) exp_err = 1'b1;
`endif
    exp_rd = '0;
    if (exp_err) begin
      exp_lat = 1;
      exp_wr  = 0;
    end else if (!we) begin
      exp_lat = 2;
      exp_wr  = 0;
      for (int k = 0; k < span; k++) exp_rd[8*k +: 8] = ref_mem[int'(a) + k];
      if (!uns && span == 1 && exp_rd[7])  exp_rd = exp_rd | 32'hFFFF_FF00;
      if (!uns && span == 2 && exp_rd[15]) exp_rd = exp_rd | 32'hFFFF_0000;
    end else begin
      exp_lat = (sz == 2'b10) ? 2 : 3;
      exp_wr  = 1;
      for (int k = 0; k < span; k++) ref_mem[int'(a) + k] = wd[8*k +: 8];
    end

    @(negedge clk);
    check({tag, "/ready"}, {31'd0, req_ready}, 32'd1);
    wr0          = wr_cnt;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "/resp_valid"}, {31'd0, resp_valid}, 32'd1);
    check({tag, "/latency"}, lat, exp_lat);
    check({tag, "/resp_err"}, {31'd0, resp_err}, {31'd0, exp_err});
    if (!we && !exp_err) check({tag, "/rdata"}, resp_rdata, exp_rd);
    if (exp_err) check({tag, "/err_rdata"}, resp_rdata, 32'd0);
    last_rdata = resp_rdata;
    check({tag, "/writes"}, wr_cnt - wr0, exp_wr);
    @(posedge clk);
    #1;
    check({tag, "/pulse_one"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "/idle_addr"}, {21'd0, mem_address}, 32'd0);
    check({tag, "/idle_wdata"}, mem_write_data, 32'd0);
  endtask

  // Sub-word store interrupted by reset after the given number of post-accept edges.
  task automatic reset_mid(input string tag, input int edges_after_accept);
    int   wr0;
    logic seen_resp;
    @(negedge clk);
    wr0          = wr_cnt;
    req_valid    = 1'b1;
    req_we       = 1'b1;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 11'h020;
    req_wdata    = 32'h0000_0055;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    seen_resp = resp_valid;
    repeat (edges_after_accept) begin
      @(posedge clk);
      #1;
      seen_resp = seen_resp | resp_valid;
    end
    rst = 1'b0;
    #1;
    check({tag, "/wen_in_reset"}, {31'd0, mem_wrt_en}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    seen_resp = seen_resp | resp_valid;
    check({tag, "/ready_after"}, {31'd0, req_ready}, 32'd1);
    repeat (3) begin
      @(posedge clk);
      #1;
      seen_resp = seen_resp | resp_valid;
    end
    check({tag, "/no_resp"}, {31'd0, seen_resp}, 32'd0);
    check({tag, "/no_write"}, wr_cnt - wr0, 0);
  endtask

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) begin
      phys_mem[i] = 8'($urandom);
      ref_mem[i]  = phys_mem[i];
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    check("rst/ready", {31'd0, req_ready}, 32'd1);
    check("rst/resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst/resp_err", {31'd0, resp_err}, 32'd0);
    check("rst/resp_rdata", resp_rdata, 32'd0);
    check("rst/mem_wen", {31'd0, mem_wrt_en}, 32'd0);
    check("rst/mem_addr", {21'd0, mem_address}, 32'd0);
    check("rst/mem_wdata", mem_write_data, 32'd0);

    do_req("st_w_010", 1'b1, 2'b10, 1'b0, 11'h010, 32'hDEAD_BEEF);
    do_req("ld_w_010", 1'b0, 2'b10, 1'b0, 11'h010, 32'h0);
    check("tp/word", last_rdata, 32'hDEAD_BEEF);
    do_req("st_b_011", 1'b1, 2'b00, 1'b0, 11'h011, 32'h0000_00AA);
    do_req("ld_w_010b", 1'b0, 2'b10, 1'b0, 11'h010, 32'h0);
    check("tp/merge", last_rdata, 32'hDEAD_AAEF);
    do_req("ld_bs_013", 1'b0, 2'b00, 1'b0, 11'h013, 32'h0);
    check("tp/byte_sext", last_rdata, 32'hFFFF_FFDE);
    do_req("ld_bu_013", 1'b0, 2'b00, 1'b1, 11'h013, 32'h0);
    check("tp/byte_zext", last_rdata, 32'h0000_00DE);
    do_req("ld_hu_010", 1'b0, 2'b01, 1'b1, 11'h010, 32'h0);
    check("tp/half_zext", last_rdata, 32'h0000_AAEF);

    do_req("st_w_7fd", 1'b1, 2'b10, 1'b0, 11'h7FD, 32'h1234_5678);
    do_req("st_w_7fc", 1'b1, 2'b10, 1'b0, 11'h7FC, 32'hCAFE_F00D);
    do_req("st_h_7fe", 1'b1, 2'b01, 1'b0, 11'h7FE, 32'h0000_9A8B);
    do_req("st_b_7ff", 1'b1, 2'b00, 1'b0, 11'h7FF, 32'h0000_0077);
    do_req("ld_w_7fc", 1'b0, 2'b10, 1'b0, 11'h7FC, 32'h0);
    check("tp/top_word", last_rdata, 32'h778B_F00D);
    do_req("ld_h_7ff", 1'b0, 2'b01, 1'b0, 11'h7FF, 32'h0);
    do_req("rsvd", 1'b0, 2'b11, 1'b0, 11'h000, 32'h0);

    reset_mid("rst_rmw", 0);
    reset_mid("rst_write", 1);
    do_req("ld_b_020", 1'b0, 2'b00, 1'b1, 11'h020, 32'h0);

    do_req("ld_w_012", 1'b0, 2'b10, 1'b0, 11'h012, 32'h0);

    for (int n = 0; n < 300; n++) begin
      logic [10:0] a;
      a = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(2040, 2047)) : 11'($urandom_range(0, 2047));
      do_req("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
